reg_window_write_port: RTL and testbench

//  Write side of the SPARC V8 windowed register file. Translates a logical

---
 rtl/reg_window_write_port.sv | 137 +++++++++++++
 tb/tb_reg_window_write_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_window_write_port.sv
// Write side of a windowed register file: maps (rd, CWP) to a physical register and runs a window clear.
// Latency: accepted write appears on regs_flat after the following edge (2 edges from request).
// Backpressure: wr_ready drops while a clear is requested or running; no writes are accepted then.
module reg_window_write_port #(
    parameter int NWIN  = 4,
    parameter int CWP_W = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    wr_en,
    input  logic [4:0]              wr_rd,
    input  logic [CWP_W-1:0]        wr_cwp,
    input  logic [31:0]             wr_data,
    output logic                    wr_ready,
    input  logic                    clr_req,
    input  logic [CWP_W-1:0]        clr_win,
    output logic                    busy,
    output logic [32*(8+16*NWIN)-1:0] regs_flat
);

    localparam int NPHYS = 8 + 16 * NWIN;
    localparam int IDX_W = $clog2(NPHYS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // First physical register of a window (its ins; locals follow at +8).
    function automatic logic [IDX_W-1:0] win_base(input int w);
        return IDX_W'(8 + 16 * w);
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CWP_W-1:0] clr_win_q, clr_win_d;
    logic             stg_vld_q, stg_vld_d;
    logic [IDX_W-1:0] stg_idx_q, stg_idx_d;
    logic [31:0]      stg_dat_q, stg_dat_d;
    logic [31:0]      regs_q [NPHYS];
    logic [31:0]      regs_d [NPHYS];

    int               w_cur;
    int               w_prev;
    logic [IDX_W-1:0] wr_phys;
    logic [IDX_W-1:0] clr_phys;
    logic             wr_accept;

    assign wr_ready  = (state_q == ST_IDLE) && !clr_req;
    assign busy      = (state_q == ST_CLEAR);
    assign wr_accept = wr_en && wr_ready;

    // Translate the logical destination into a physical index; outs alias the ins of window w-1.
    always_comb begin
        w_cur   = int'(wr_cwp) % NWIN;
        w_prev  = (w_cur + NWIN - 1) % NWIN;
        wr_phys = '0;
        case (wr_rd[4:3])
            2'b00:   wr_phys = IDX_W'(wr_rd);
            2'b01:   wr_phys = win_base(w_prev) + IDX_W'(wr_rd[2:0]);
            2'b10:   wr_phys = win_base(w_cur) + IDX_W'({1'b1, wr_rd[2:0]});
            default: wr_phys = win_base(w_cur) + IDX_W'(wr_rd[2:0]);
        endcase
        clr_phys = win_base(int'(clr_win_q)) + IDX_W'(cnt_q);
    end

    // Clear sequencer: one register of the selected window zeroed per cycle, 16 cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_win_d = clr_win_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = 4'd0;
                    clr_win_d = CWP_W'(int'(clr_win) % NWIN);
                end
            end
            default: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Stage register holds the translated write for one cycle before commit.
    always_comb begin
        stg_vld_d = wr_accept;
        stg_idx_d = stg_idx_q;
        stg_dat_d = stg_dat_q;
        if (wr_accept) begin
            stg_idx_d = wr_phys;
            stg_dat_d = wr_data;
        end
    end

    // Array update: staged write first, clear applied after so it wins a collision; r0 pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (stg_vld_q) begin
            regs_d[stg_idx_q] = stg_dat_q;
        end
        if (state_q == ST_CLEAR) begin
            regs_d[clr_phys] = 32'h0;
        end
        regs_d[0] = 32'h0;
    end

    // State, stage and register array flops with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            clr_win_q <= '0;
            stg_vld_q <= 1'b0;
            stg_idx_q <= '0;
            stg_dat_q <= 32'h0;
            for (int i = 0; i < NPHYS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_win_q <= clr_win_d;
            stg_vld_q <= stg_vld_d;
            stg_idx_q <= stg_idx_d;
            stg_dat_q <= stg_dat_d;
            regs_q    <= regs_d;
        end
    end

    for (genvar p = 0; p < NPHYS; p++) begin : g_flat
        assign regs_flat[32*p +: 32] = regs_q[p];
    end

endmodule

// File: tb/tb_reg_window_write_port.sv
// Directed bench for reg_window_write_port: table-driven single writes plus clear/reset sequences.
// Latency: checks values one and two edges after each accepted write.
// Backpressure: checks wr_ready/busy during clear requests and the clear sequence.
module tb_reg_window_write_port;

    localparam int NWIN  = 4;
    localparam int CWP_W = 2;
    localparam int NPHYS = 8 + 16 * NWIN;

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic                   wr_en;
    logic [4:0]             wr_rd;
    logic [CWP_W-1:0]       wr_cwp;
    logic [31:0]            wr_data;
    logic                   wr_ready;
    logic                   clr_req;
    logic [CWP_W-1:0]       clr_win;
    logic                   busy;
    logic [32*NPHYS-1:0]    regs_flat;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NPHYS];

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  cwp;
        logic [31:0] dat;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    reg_window_write_port #(.NWIN(NWIN), .CWP_W(CWP_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_cwp    (wr_cwp),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_req   (clr_req),
        .clr_win   (clr_win),
        .busy      (busy),
        .regs_flat (regs_flat)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] phys(input int i);
        return regs_flat[32*i +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-file comparison against the model; counts as one comparison.
    task automatic check_all(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < NPHYS; i++) begin
            if (phys(i) !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d regs differ, first phys%0d got %h expected %h",
                     name, bad, first, phys(first), model[first]);
        end
    endtask

    // Waits for busy to drop; a bound expiry is a failed comparison.
    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            @(negedge Clk);
            cycles++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: busy stuck high, got %b expected 0", name, busy);
        end
    endtask

    initial begin
        int  n;
        int  ready_hi;
        int  ph;
        Reset   = 1'b1;
        wr_en   = 1'b0;
        wr_rd   = '0;
        wr_cwp  = '0;
        wr_data = '0;
        clr_req = 1'b0;
        clr_win = '0;
        for (int i = 0; i < NPHYS; i++) model[i] = 32'h0;

        vecs[0] = '{5'd5,  2'd0, 32'h0000_0011, 5,  32'h0000_0011};
        vecs[1] = '{5'd0,  2'd0, 32'hFFFF_FFFF, 0,  32'h0000_0000};
        vecs[2] = '{5'd8,  2'd1, 32'hDEAD_BEEF, 8,  32'hDEAD_BEEF};
        vecs[3] = '{5'd8,  2'd0, 32'hA5A5_A5A5, 56, 32'hA5A5_A5A5};
        vecs[4] = '{5'd16, 2'd2, 32'h0000_1234, 48, 32'h0000_1234};
        vecs[5] = '{5'd31, 2'd3, 32'hCAFE_0001, 63, 32'hCAFE_0001};
        vecs[6] = '{5'd24, 2'd1, 32'h0000_0024, 24, 32'h0000_0024};
        vecs[7] = '{5'd23, 2'd0, 32'h0000_0077, 23, 32'h0000_0077};
        vecs[8] = '{5'd15, 2'd2, 32'h0000_0015, 31, 32'h0000_0015};
        vecs[9] = '{5'd7,  2'd3, 32'h0000_0007, 7,  32'h0000_0007};

        repeat (2) @(negedge Clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_ready", {31'h0, wr_ready}, 32'h1);
        check_all("reset_regs");
        Reset = 1'b0;
        @(negedge Clk);

        // Single writes: value must be absent after one edge, present after two.
        for (int v = 0; v < 10; v++) begin
            wr_en   = 1'b1;
            wr_rd   = vecs[v].rd;
            wr_cwp  = vecs[v].cwp;
            wr_data = vecs[v].dat;
            @(negedge Clk);
            wr_en = 1'b0;
            check($sformatf("vec%0d_stage", v), phys(vecs[v].idx), model[vecs[v].idx]);
            @(negedge Clk);
            model[vecs[v].idx] = vecs[v].exp;
            check($sformatf("vec%0d_commit", v), phys(vecs[v].idx), vecs[v].exp);
            check_all($sformatf("vec%0d_all", v));
        end

        // Back-to-back writes to the same target: last wins.
        wr_en = 1'b1; wr_rd = 5'd20; wr_cwp = 2'd0; wr_data = 32'h0000_AAAA;
        @(negedge Clk);
        wr_data = 32'h0000_BBBB;
        @(negedge Clk);
        wr_en = 1'b0;
        check("b2b_first", phys(20), 32'h0000_AAAA);
        @(negedge Clk);
        model[20] = 32'h0000_BBBB;
        check("b2b_last", phys(20), 32'h0000_BBBB);

        // Fill phys 8..71 through ins/locals of every window, one write per cycle.
        for (int w = 0; w < NWIN; w++) begin
            for (int k = 0; k < 16; k++) begin
                wr_en   = 1'b1;
                wr_cwp  = CWP_W'(w);
                wr_rd   = (k < 8) ? 5'(24 + k) : 5'(16 + k - 8);
                wr_data = 32'h1000_0000 | 32'(8 + 16*w + k);
                model[8 + 16*w + k] = wr_data;
                @(negedge Clk);
            end
        end
        wr_en = 1'b0;
        @(negedge Clk);
        check_all("fill");

        // Clear window 1 while a write is held pending; it must never be accepted.
        clr_req = 1'b1; clr_win = 2'd1;
        wr_en = 1'b1; wr_rd = 5'd24; wr_cwp = 2'd1; wr_data = 32'h0000_0BAD;
        #1;
        check("clr_req_blocks_ready", {31'h0, wr_ready}, 32'h0);
        @(negedge Clk);
        clr_req = 1'b0;
        n = 0;
        ready_hi = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (wr_ready !== 1'b0) ready_hi++;
            @(negedge Clk);
        end
        wr_en = 1'b0;
        check("clear_busy_cycles", 32'(n), 32'd16);
        check("clear_ready_low", 32'(ready_hi), 32'd0);
        for (int i = 24; i < 40; i++) model[i] = 32'h0;
        @(negedge Clk);
        check_all("clear_win1");

        // Staged write commits as the clear starts; simultaneous write+clear is refused.
        wr_en = 1'b1; wr_rd = 5'd24; wr_cwp = 2'd2; wr_data = 32'h0000_5151;
        @(negedge Clk);
        wr_rd = 5'd25; wr_data = 32'h0000_6262;
        clr_req = 1'b1; clr_win = 2'd1;
        #1;
        check("simul_ready", {31'h0, wr_ready}, 32'h0);
        @(negedge Clk);
        wr_en = 1'b0; clr_req = 1'b0;
        check("simul_busy", {31'h0, busy}, 32'h1);
        wait_idle("simul_clear", n);
        model[40] = 32'h0000_5151;
        @(negedge Clk);
        check("staged_commit", phys(40), 32'h0000_5151);
        check("simul_not_written", phys(41), model[41]);
        check_all("simul_all");

        // Reset asserted during the seventh clear cycle.
        clr_req = 1'b1; clr_win = 2'd2;
        @(negedge Clk);
        clr_req = 1'b0;
        repeat (6) @(negedge Clk);
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        for (int i = 0; i < NPHYS; i++) model[i] = 32'h0;
        check("midclear_reset_busy", {31'h0, busy}, 32'h0);
        check_all("midclear_reset_regs");
        @(negedge Clk);
        Reset = 1'b0;
        check("post_reset_ready", {31'h0, wr_ready}, 32'h1);

        // Staged write dropped by reset, then a normal write still works.
        wr_en = 1'b1; wr_rd = 5'd6; wr_cwp = 2'd0; wr_data = 32'h0000_0066;
        @(negedge Clk);
        wr_en = 1'b0;
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("staged_dropped", phys(6), 32'h0);
        wr_en = 1'b1; wr_rd = 5'd5; wr_data = 32'h0000_0011;
        @(negedge Clk);
        wr_en = 1'b0;
        @(negedge Clk);
        model[5] = 32'h0000_0011;
        ph = 5;
        check("post_reset_write", phys(ph), 32'h0000_0011);
        check_all("final_all");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
